// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: deserializer state encoding,
// supported data-width limits and the mid-bit sample index helper.
package uart_rx_pkg;

    // Deserializer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } rx_deser_state_e;

    // Supported range of data bits per frame
    localparam int unsigned DATA_WIDTH_MIN = 5;
    localparam int unsigned DATA_WIDTH_MAX = 16;

    // Oversample index at which a bit is sampled; callers truncate to their width
    function automatic logic [31:0] mid_sample_idx(input logic [31:0] prescale);
        return prescale >> 1;
    endfunction

endpackage

// File: rtl/rx_sample_strobe.sv
// Mid-bit sample strobe: asserted while the frame-data window is open and the
// oversample edge counter sits on the mid-bit index (Prescale >> 1).
module rx_sample_strobe
    import uart_rx_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  deser_en_i,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  strobe_o
);

    logic [PRESCALE_W-1:0] mid_idx;

    // Compare at PRESCALE_W bits; Prescale of 0 or 1 lands the strobe on edge 0
    always_comb begin
        mid_idx  = PRESCALE_W'(mid_sample_idx(32'(prescale_i)));
        strobe_o = deser_en_i && (edge_cnt_i == mid_idx);
    end

endmodule

// File: rtl/rx_deser_param.sv
// UART RX deserializer: captures sampled bits at the mid-bit strobe, counts
// them against a per-frame length latched at frame start, and presents a
// right-justified word with a one-cycle data_valid pulse.
// Optional feature macro: RX_DESER_PARITY_EN adds par_type / par_calc.
module rx_deser_param
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned LEN_W      = 5
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic                  deser_en,
    input  logic                  sampled_bit,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [LEN_W-1:0]      data_len,
    input  logic                  msb_first,
`ifdef RX_DESER_PARITY_EN
    input  logic                  par_type,
    output logic                  par_calc,
`endif
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic [LEN_W-1:0]      bit_cnt,
    output logic                  busy
);

    localparam logic [LEN_W-1:0] DW_L = LEN_W'(DATA_WIDTH);

    rx_deser_state_e       state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  msb_q, msb_d;

    logic                  strobe;
    logic                  cap;
    logic [LEN_W-1:0]      eff_len_in;
    logic [LEN_W-1:0]      cur_len;
    logic                  cur_msb;
    logic [DATA_WIDTH-1:0] sr_base;
    logic [DATA_WIDTH-1:0] sr_next;
    logic [LEN_W-1:0]      cnt_base;
    logic [LEN_W-1:0]      cnt_inc;
    logic [LEN_W-1:0]      shamt;

`ifdef RX_DESER_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic par_type_q, par_type_d;
    logic par_calc_q, par_calc_d;
    logic par_base;
    logic cur_par_type;
`endif

    rx_sample_strobe #(
        .PRESCALE_W (PRESCALE_W)
    ) u_strobe (
        .deser_en_i (deser_en),
        .edge_cnt_i (edge_cnt),
        .prescale_i (Prescale),
        .strobe_o   (strobe)
    );

    // Next-state, capture and word alignment
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        p_data_d   = p_data_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        msb_d      = msb_q;
        cap        = 1'b0;
        cur_len    = len_q;
        cur_msb    = msb_q;
        sr_base    = sr_q;
        cnt_base   = cnt_q;
        sr_next    = sr_q;
        cnt_inc    = cnt_q;
        shamt      = '0;
        // Out-of-range lengths fall back to the full data width
        eff_len_in = ((data_len != '0) && (data_len <= DW_L)) ? data_len : DW_L;
`ifdef RX_DESER_PARITY_EN
        par_acc_d    = par_acc_q;
        par_type_d   = par_type_q;
        par_calc_d   = par_calc_q;
        par_base     = par_acc_q;
        cur_par_type = par_type_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (deser_en) begin
                    len_d    = eff_len_in;
                    msb_d    = msb_first;
                    cur_len  = eff_len_in;
                    cur_msb  = msb_first;
                    sr_base  = '0;
                    cnt_base = '0;
                    sr_d     = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                    // A strobe coinciding with frame start is bit 0
                    cap      = strobe;
`ifdef RX_DESER_PARITY_EN
                    par_type_d   = par_type;
                    cur_par_type = par_type;
                    par_base     = 1'b0;
                    par_acc_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (!deser_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cap = strobe;
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!deser_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap) begin
            sr_next = cur_msb ? {sr_base[DATA_WIDTH-2:0], sampled_bit}
                              : {sampled_bit, sr_base[DATA_WIDTH-1:1]};
            cnt_inc = cnt_base + LEN_W'(1);
            sr_d    = sr_next;
            cnt_d   = cnt_inc;
`ifdef RX_DESER_PARITY_EN
            par_acc_d = par_base ^ sampled_bit;
`endif
            if (cnt_inc == cur_len) begin
                state_d  = DONE;
                // LSB-first words sit at the top of the register; shift them down
                shamt    = DW_L - cur_len;
                p_data_d = cur_msb ? sr_next : (sr_next >> shamt);
`ifdef RX_DESER_PARITY_EN
                par_calc_d = par_base ^ sampled_bit ^ cur_par_type;
`endif
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            p_data_q <= '0;
            cnt_q    <= '0;
            len_q    <= DW_L;
            msb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            p_data_q <= p_data_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            msb_q    <= msb_d;
        end
    end

`ifdef RX_DESER_PARITY_EN
    // Parity accumulator, latched parity type and published parity
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            par_acc_q  <= 1'b0;
            par_type_q <= 1'b0;
            par_calc_q <= 1'b0;
        end else begin
            par_acc_q  <= par_acc_d;
            par_type_q <= par_type_d;
            par_calc_q <= par_calc_d;
        end
    end

    assign par_calc = par_calc_q;
`endif

    // Outputs; P_DATA is already updated during the DONE cycle
    always_comb begin
        P_DATA     = p_data_q;
        data_valid = (state_q == DONE);
        bit_cnt    = cnt_q;
        busy       = (state_q == SHIFT);
    end

endmodule

// File: tb/tb_rx_deser_param.sv
// Self-checking bench for rx_deser_param (DATA_WIDTH=8): directed frames push
// expected words into a scoreboard; a monitor pops on every data_valid.
module tb_rx_deser_param;

    logic       clk = 1'b0;
    logic       ARSTn = 1'b0;
    logic       deser_en = 1'b0;
    logic       sampled_bit = 1'b0;
    logic [5:0] edge_cnt = '0;
    logic [5:0] Prescale = 6'd8;
    logic [4:0] data_len = 5'd8;
    logic       msb_first = 1'b0;
    logic       par_type = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic [4:0] bit_cnt;
    logic       busy;
`ifdef RX_DESER_PARITY_EN
    logic       par_calc;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic       exp_par_q[$];

    rx_deser_param #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6),
        .LEN_W      (5)
    ) dut (
        .clk         (clk),
        .ARSTn       (ARSTn),
        .deser_en    (deser_en),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .Prescale    (Prescale),
        .data_len    (data_len),
        .msb_first   (msb_first),
`ifdef RX_DESER_PARITY_EN
        .par_type    (par_type),
        .par_calc    (par_calc),
`endif
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .bit_cnt     (bit_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (ARSTn && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got P_DATA %0h expected no valid", P_DATA);
            end else begin
                chk("word", 32'(P_DATA), 32'(exp_q.pop_front()));
                chk("latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
`ifdef RX_DESER_PARITY_EN
                chk("par_calc", 32'(par_calc), 32'(exp_par_q.pop_front()));
`else
                void'(exp_par_q.pop_front());
`endif
            end
        end
    end

    // Drives one frame; bits[i] is the i-th transmitted bit. The expectation is
    // queued at the strobe of bit last_idx (-1: no word expected).
    task automatic run_frame(input logic [15:0] bits, input int n_sent, input int last_idx,
                             input logic [4:0] len, input logic msb, input bit flip,
                             input logic [7:0] exp_word, input logic ptype);
        int cycles;
        int mid;
        cycles    = (Prescale < 6'd2) ? 1 : int'(Prescale);
        mid       = int'(Prescale >> 1);
        data_len  = len;
        msb_first = msb;
        par_type  = ptype;
        for (int i = 0; i < n_sent; i++) begin
            if (flip && i == 1) begin
                data_len  = 5'd5;
                msb_first = ~msb;
                par_type  = ~ptype;
            end
            for (int e = 0; e < cycles; e++) begin
                deser_en    = 1'b1;
                sampled_bit = bits[i];
                edge_cnt    = 6'(e);
                if (i == last_idx && e == mid) begin
                    exp_q.push_back(exp_word);
                    exp_cyc_q.push_back(cyc + 1);
                    exp_par_q.push_back((^exp_word) ^ ptype);
                end
                @(posedge clk);
                #1;
            end
        end
        deser_en = 1'b0;
        edge_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("reset_p_data", 32'(P_DATA), 32'h0);
        chk("reset_valid", 32'(data_valid), 32'h0);
        chk("reset_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        ARSTn = 1'b1;
        @(posedge clk);
        #1;

        run_frame(16'h00A5, 8, 7, 5'd8, 1'b0, 1'b0, 8'hA5, 1'b0);  // LSB-first
        run_frame(16'h00A5, 8, 7, 5'd8, 1'b1, 1'b0, 8'hA5, 1'b1);  // MSB-first, odd
        run_frame(16'h00AC, 8, 7, 5'd8, 1'b1, 1'b0, 8'h35, 1'b0);  // 0,0,1,1,0,1,0,1
        run_frame(16'h0013, 5, 4, 5'd5, 1'b0, 1'b0, 8'h13, 1'b0);  // 5-bit LSB
        run_frame(16'h00A5, 8, 7, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b0);  // len 0 -> 8
        run_frame(16'h00AC, 8, 7, 5'd12, 1'b0, 1'b0, 8'hAC, 1'b1); // len 12 -> 8
        run_frame(16'h00A5, 8, 7, 5'd8, 1'b0, 1'b1, 8'hA5, 1'b0);  // mid-frame changes ignored

        Prescale = 6'd1;  // strobe every cycle, including the frame-start cycle
        run_frame(16'h00AC, 8, 7, 5'd8, 1'b1, 1'b0, 8'h35, 1'b0);
        Prescale = 6'd8;

        // Abort after 4 captures keeps the prior word
        run_frame(16'h00A5, 8, 7, 5'd8, 1'b0, 1'b0, 8'hA5, 1'b0);
        run_frame(16'h00FF, 4, -1, 5'd8, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("abort_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("abort_p_data", 32'(P_DATA), 32'hA5);
        chk("abort_busy", 32'(busy), 32'h0);

        // Extra strobes after a complete frame are ignored
        run_frame(16'h023C, 11, 7, 5'd8, 1'b0, 1'b0, 8'h3C, 1'b0);
        chk("extra_p_data", 32'(P_DATA), 32'h3C);
        chk("extra_bit_cnt_idle", 32'(bit_cnt), 32'h0);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < 8; e++) begin
                deser_en    = 1'b1;
                sampled_bit = 1'b1;
                edge_cnt    = 6'(e);
                @(posedge clk);
                #1;
            end
        end
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_bit_cnt", 32'(bit_cnt), 32'h3);
        #2;
        ARSTn = 1'b0;
        #1;
        chk("arst_p_data", 32'(P_DATA), 32'h0);
        chk("arst_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_valid", 32'(data_valid), 32'h0);
`ifdef RX_DESER_PARITY_EN
        chk("arst_par_calc", 32'(par_calc), 32'h0);
`endif
        deser_en = 1'b0;
        #3;
        ARSTn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
